pc_seq_ctrl: RTL and testbench

- Control-flow sequencer that drives the PC_circuit select inputs: JMP, BRANCH, flag_Rd_PC, flag_label_PC and flag_Rm_PC.
- Evaluates branch conditions against the NZCV flags, gates PC advance with stall and halt, and inserts a one-cycle flush after a taken redirect.
- Raises the link-register write for branch-and-link.
- Sits between the instruction decoder and PC_circuit; the datapath tap is the current PC.

---
 rtl/pc_seq_ctrl_pkg.sv | 46 ++++
 rtl/pc_cond_eval.sv | 43 ++++
 rtl/pc_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// Shared encodings for the PC control-flow sequencer: control-flow types,
// condition codes, sequencer states and NZCV flag bit positions.
package pc_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        CF_NONE      = 3'd0,
        CF_BCOND     = 3'd1,
        CF_JMP_LABEL = 3'd2,
        CF_JMP_RD    = 3'd3,
        CF_JMP_RM    = 3'd4,
        CF_BL        = 3'd5
    } cf_type_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_STALL = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_e;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

endpackage

// File: rtl/pc_cond_eval.sv
// Combinational condition-code evaluator: decides whether a conditional
// control-flow instruction is taken given the current NZCV flags.
module pc_cond_eval
    import pc_seq_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       take
);

    logic n, z, c, v;

    always_comb begin
        n = nzcv[NZCV_N];
        z = nzcv[NZCV_Z];
        c = nzcv[NZCV_C];
        v = nzcv[NZCV_V];
    end

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_MI: take = n;
            COND_PL: take = !n;
            COND_VS: take = v;
            COND_VC: take = !v;
            COND_HI: take = c && !z;
            COND_LS: take = !c || z;
            COND_GE: take = (n == v);
            COND_LT: take = (n != v);
            COND_GT: take = !z && (n == v);
            COND_LE: take = z || (n != v);
            COND_AL: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Control-flow sequencer driving the PC_circuit selects: resolves branches
// and jumps, gates PC advance on stall/halt and inserts a flush after redirects.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_EN = 1,
    parameter int unsigned CNT_W    = 16
)
(
    input  logic             clk,
    input  logic             clr,
    input  logic             instr_valid,
    input  logic [2:0]       cf_type,
    input  logic [3:0]       cond,
    input  logic [3:0]       nzcv,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    input  logic [15:0]      pc_q,
    output logic             JMP,
    output logic             BRANCH,
    output logic             flag_Rd_PC,
    output logic             flag_label_PC,
    output logic             flag_Rm_PC,
    output logic             pc_en,
    output logic             flush,
    output logic             link_we,
    output logic [15:0]      link_data,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] taken_cnt
);

    seq_state_e       state_q, state_d;
    logic             cond_take;
    logic             redirect;
    logic [CNT_W-1:0] cnt_q;

    pc_cond_eval u_cond_eval (
        .cond (cond),
        .nzcv (nzcv),
        .take (cond_take)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:   state_d = ST_RUN;
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_STALL;
                end else if (redirect && (FLUSH_EN != 0)) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: state_d = halt_req ? ST_HALT : ST_RUN;
            ST_STALL: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (!stall) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STALL;
                end
            end
            ST_HALT:  state_d = resume ? ST_RUN : ST_HALT;
            default:  state_d = ST_RST;
        endcase
    end

    // Selects are only issued from RUN with neither halt nor stall pending.
    always_comb begin
        JMP           = 1'b0;
        BRANCH        = 1'b0;
        flag_Rd_PC    = 1'b0;
        flag_label_PC = 1'b0;
        flag_Rm_PC    = 1'b0;
        pc_en         = 1'b0;
        flush         = 1'b0;
        link_we       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!halt_req && !stall) begin
                    pc_en = 1'b1;
                    if (instr_valid) begin
                        case (cf_type)
                            CF_BCOND:     BRANCH = cond_take;
                            CF_JMP_LABEL: begin
                                JMP           = 1'b1;
                                flag_label_PC = 1'b1;
                            end
                            CF_JMP_RD: begin
                                JMP        = 1'b1;
                                flag_Rd_PC = 1'b1;
                            end
                            CF_JMP_RM: begin
                                JMP        = 1'b1;
                                flag_Rm_PC = 1'b1;
                            end
                            CF_BL: begin
                                JMP           = 1'b1;
                                flag_label_PC = 1'b1;
                                link_we       = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                pc_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign redirect = JMP || BRANCH;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else if (redirect && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign taken_cnt = cnt_q;
    assign state     = state_q;
    assign link_data = pc_q + 16'd1;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios plus a reference
// model compared against the DUT every cycle.
module tb_pc_seq_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int M_RST = 0, M_RUN = 1, M_FLUSH = 2, M_STALL = 3, M_HALT = 4;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             instr_valid = 1'b0;
    logic [2:0]       cf_type = '0;
    logic [3:0]       cond = '0;
    logic [3:0]       nzcv = '0;
    logic             stall = 1'b0;
    logic             halt_req = 1'b0;
    logic             resume = 1'b0;
    logic [15:0]      pc_q = '0;
    logic             JMP, BRANCH, flag_Rd_PC, flag_label_PC, flag_Rm_PC;
    logic             pc_en, flush, link_we;
    logic [15:0]      link_data;
    logic [2:0]       state;
    logic [CNT_W-1:0] taken_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pc_seq_ctrl #(.FLUSH_EN(1), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .clr           (clr),
        .instr_valid   (instr_valid),
        .cf_type       (cf_type),
        .cond          (cond),
        .nzcv          (nzcv),
        .stall         (stall),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc_q          (pc_q),
        .JMP           (JMP),
        .BRANCH        (BRANCH),
        .flag_Rd_PC    (flag_Rd_PC),
        .flag_label_PC (flag_label_PC),
        .flag_Rm_PC    (flag_Rm_PC),
        .pc_en         (pc_en),
        .flush         (flush),
        .link_we       (link_we),
        .link_data     (link_data),
        .state         (state),
        .taken_cnt     (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Conditions come in true/inverted pairs; odd codes invert the even base.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        logic [2:0] pair;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        pair = c[3:1];
        case (pair)
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    int         m_mode = M_RST;
    int         m_next = M_RST;
    int         m_cnt = 0;
    int         m_cnt_next = 0;

    always @(negedge clk) begin
        logic [4:0] e_sel; // {JMP,BRANCH,Rd,label,Rm}
        logic e_pc_en, e_flush, e_link, taken;
        e_sel = '0; e_pc_en = 0; e_flush = 0; e_link = 0; taken = 0;
        m_next = m_mode;
        case (m_mode)
            M_RST: m_next = M_RUN;
            M_RUN: begin
                if (halt_req) m_next = M_HALT;
                else if (stall) m_next = M_STALL;
                else begin
                    e_pc_en = 1;
                    if (instr_valid) begin
                        if (cf_type == 1 && cond_holds(cond, nzcv)) e_sel = 5'b01000;
                        if (cf_type == 2) e_sel = 5'b10010;
                        if (cf_type == 3) e_sel = 5'b10100;
                        if (cf_type == 4) e_sel = 5'b10001;
                        if (cf_type == 5) begin e_sel = 5'b10010; e_link = 1; end
                    end
                    taken = (e_sel != 0);
                    m_next = taken ? M_FLUSH : M_RUN;
                end
            end
            M_FLUSH: begin
                e_flush = 1; e_pc_en = 1;
                m_next = halt_req ? M_HALT : M_RUN;
            end
            M_STALL: m_next = halt_req ? M_HALT : (stall ? M_STALL : M_RUN);
            default: m_next = resume ? M_RUN : M_HALT;
        endcase
        m_cnt_next = (taken && m_cnt < 15) ? m_cnt + 1 : m_cnt;
        check("state", 32'(state), 32'(m_mode));
        check("selects", 32'({JMP, BRANCH, flag_Rd_PC, flag_label_PC, flag_Rm_PC}), 32'(e_sel));
        check("pc_en", 32'(pc_en), 32'(e_pc_en));
        check("flush", 32'(flush), 32'(e_flush));
        check("link_we", 32'(link_we), 32'(e_link));
        check("link_data", 32'(link_data), 32'((32'(pc_q) + 1) % 65536));
        check("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
    end

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_mode <= M_RST;
            m_cnt  <= 0;
        end else begin
            m_mode <= m_next;
            m_cnt  <= m_cnt_next;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        instr_valid = 0; cf_type = 0; cond = 0; nzcv = 0;
        stall = 0; halt_req = 0; resume = 0;
    endtask

    task automatic issue(input logic [2:0] cf, input logic [3:0] cd, input logic [3:0] f);
        instr_valid = 1; cf_type = cf; cond = cd; nzcv = f;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] jcf [3];
        logic [4:0] jsel [3];
        jcf[0] = 3'd3; jsel[0] = 5'b10100;
        jcf[1] = 3'd4; jsel[1] = 5'b10001;
        jcf[2] = 3'd2; jsel[2] = 5'b10010;

        // Reset release just after an edge gives one full RST cycle.
        #16 clr = 1;
        @(negedge clk);
        check("lit_rst_state", 32'(state), 0);
        check("lit_rst_pc_en", 32'(pc_en), 0);
        check("lit_rst_cnt", 32'(taken_cnt), 0);
        tick;
        @(negedge clk);
        check("lit_run_state", 32'(state), 1);
        check("lit_run_pc_en", 32'(pc_en), 1);

        tick; issue(3'd1, 4'h0, 4'b0100);
        @(negedge clk);
        check("lit_beq_taken", 32'(BRANCH), 1);
        tick; idle_inputs();
        @(negedge clk);
        check("lit_flush", 32'(flush), 1);
        check("lit_cnt1", 32'(taken_cnt), 1);
        tick; issue(3'd1, 4'h0, 4'b0000);
        @(negedge clk);
        check("lit_beq_not", 32'(BRANCH), 0);
        tick; idle_inputs();
        @(negedge clk);
        check("lit_no_flush", 32'(flush), 0);

        for (int i = 0; i < 3; i++) begin
            tick; issue(jcf[i], 4'h0, 4'h0);
            @(negedge clk);
            check("lit_jump_sel", 32'({JMP, BRANCH, flag_Rd_PC, flag_label_PC, flag_Rm_PC}), 32'(jsel[i]));
            tick; idle_inputs();
        end
        tick; issue(3'd5, 4'h0, 4'h0); pc_q = 16'hFFFF;
        @(negedge clk);
        check("lit_bl_link_we", 32'(link_we), 1);
        check("lit_bl_link_data", 32'(link_data), 0);
        tick; idle_inputs(); pc_q = 16'h0100;

        tick; issue(3'd2, 4'h0, 4'h0); stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lit_stall_pc_en", 32'(pc_en), 0);
            check("lit_stall_jmp", 32'(JMP), 0);
            tick;
        end
        stall = 0;
        @(negedge clk);
        check("lit_stall_state", 32'(state), 3);
        tick;
        @(negedge clk);
        check("lit_held_jmp", 32'(JMP), 1);
        check("lit_cnt_pre", 32'(taken_cnt), 5);
        tick; idle_inputs();
        @(negedge clk);
        check("lit_cnt_once", 32'(taken_cnt), 6);

        tick; halt_req = 1; stall = 1;
        @(negedge clk);
        check("lit_halt_pc_en", 32'(pc_en), 0);
        tick; stall = 0;
        @(negedge clk);
        check("lit_halt_state", 32'(state), 4);
        tick; resume = 1;
        tick; idle_inputs();
        @(negedge clk);
        check("lit_resume_run", 32'(state), 1);

        for (int i = 0; i < 17; i++) begin
            issue(3'd2, 4'h0, 4'h0);
            tick; idle_inputs();
            tick;
        end
        @(negedge clk);
        check("lit_cnt_sat", 32'(taken_cnt), 15);

        for (int i = 0; i < 300; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            cf_type     = 3'($urandom_range(0, 7));
            cond        = 4'($urandom_range(0, 15));
            nzcv        = 4'($urandom_range(0, 15));
            stall       = ($urandom_range(0, 3) == 0);
            halt_req    = ($urandom_range(0, 7) == 0);
            resume      = 1'($urandom_range(0, 1));
            pc_q        = 16'($urandom);
            tick;
        end

        idle_inputs(); halt_req = 1;
        tick; tick;
        @(negedge clk);
        check("lit_halt_again", 32'(state), 4);
        tick;
        #2 clr = 0;
        #1;
        check("lit_async_state", 32'(state), 0);
        check("lit_async_cnt", 32'(taken_cnt), 0);
        tick; clr = 1; idle_inputs();
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
